// File: rtl/array_allocator.sv
// Array allocation responder: hands out array handles, recycles freed ones LIFO,
// and tracks per-array sizes, answering one request every three cycles.
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic [1:0]                    reqOp,
  input  logic [MemoryElementWidth-1:0] reqArray,
  input  logic [MemoryElementWidth-1:0] reqIndex,
  output logic                          respValid,
  output logic [MemoryElementWidth-1:0] respData,
  output logic                          respError,
  output logic [MemoryElementWidth-1:0] inUse,
  output logic [MemoryElementWidth-1:0] highWater
);

  localparam int W  = MemoryElementWidth;
  localparam int HW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int CW = $clog2(NArrays + 1);

  localparam logic [1:0] OP_ALLOC  = 2'd0;
  localparam logic [1:0] OP_FREE   = 2'd1;
  localparam logic [1:0] OP_RESIZE = 2'd2;
  localparam logic [1:0] OP_SIZE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg;
  logic            ready_reg;
  logic [1:0]      op_reg;
  logic [W-1:0]    array_reg;
  logic [W-1:0]    index_reg;

  logic [CW-1:0]   allocs_reg;
  logic [CW-1:0]   freed_top_reg;
  logic [HW-1:0]   freed_reg [NArrays];
  logic [W-1:0]    sizes_reg [NArrays];
  logic [NArrays-1:0] live_reg;
  logic [W-1:0]    in_use_reg;
  logic [W-1:0]    high_water_reg;

  logic [W-1:0]    result_data_reg;
  logic            result_err_reg;
  logic            resp_valid_reg;
  logic [W-1:0]    resp_data_reg;
  logic            resp_err_reg;

  logic [HW-1:0]   slot;
  logic            handle_ok;
  logic [W:0]      grow;
  logic            stack_empty;
  logic            alloc_full;
  logic [HW-1:0]   pop_slot;
  logic [HW-1:0]   new_handle;
  logic [W-1:0]    in_use_inc;

  always_comb begin
    slot        = array_reg[HW-1:0];
    handle_ok   = 1'b0;
    if (array_reg < W'(NArrays)) begin
      handle_ok = live_reg[slot];
    end
    // Index+1 is formed one bit wider so an all-ones index shows up as grow[W].
    grow        = {1'b0, index_reg} + (W+1)'(1);
    stack_empty = (freed_top_reg == '0);
    alloc_full  = (allocs_reg == CW'(NArrays));
    pop_slot    = freed_top_reg[HW-1:0] - HW'(1);
    new_handle  = stack_empty ? allocs_reg[HW-1:0] : freed_reg[pop_slot];
    in_use_inc  = in_use_reg + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b0;
      op_reg          <= OP_ALLOC;
      array_reg       <= '0;
      index_reg       <= '0;
      allocs_reg      <= '0;
      freed_top_reg   <= '0;
      live_reg        <= '0;
      in_use_reg      <= '0;
      high_water_reg  <= '0;
      result_data_reg <= '0;
      result_err_reg  <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= '0;
      resp_err_reg    <= 1'b0;
      for (int i = 0; i < NArrays; i++) begin
        freed_reg[i] <= '0;
        sizes_reg[i] <= '0;
      end
    end else begin
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reqValid && ready_reg) begin
            op_reg    <= reqOp;
            array_reg <= reqArray;
            index_reg <= reqIndex;
            ready_reg <= 1'b0;
            state_reg <= EXEC;
          end else begin
            ready_reg <= 1'b1;
          end
        end

        EXEC: begin
          result_data_reg <= '0;
          result_err_reg  <= 1'b1;
          case (op_reg)
            OP_ALLOC: begin
              if (!stack_empty || !alloc_full) begin
                if (!stack_empty) begin
                  freed_top_reg <= freed_top_reg - CW'(1);
                end else begin
                  allocs_reg <= allocs_reg + CW'(1);
                end
                sizes_reg[new_handle] <= '0;
                live_reg[new_handle]  <= 1'b1;
                in_use_reg            <= in_use_inc;
                if (in_use_inc > high_water_reg) begin
                  high_water_reg <= in_use_inc;
                end
                result_data_reg <= W'(new_handle);
                result_err_reg  <= 1'b0;
              end
            end
            OP_FREE: begin
              // Liveness gating means a push never lands beyond the handles issued.
              if (handle_ok) begin
                freed_reg[freed_top_reg[HW-1:0]] <= slot;
                freed_top_reg   <= freed_top_reg + CW'(1);
                sizes_reg[slot] <= '0;
                live_reg[slot]  <= 1'b0;
                in_use_reg      <= in_use_reg - W'(1);
                result_data_reg <= array_reg;
                result_err_reg  <= 1'b0;
              end
            end
            OP_RESIZE: begin
              if (handle_ok && !grow[W]) begin
                if ({1'b0, sizes_reg[slot]} < grow) begin
                  sizes_reg[slot] <= grow[W-1:0];
                end
                result_data_reg <= array_reg;
                result_err_reg  <= 1'b0;
              end
            end
            default: begin
              if (handle_ok) begin
                result_data_reg <= sizes_reg[slot];
                result_err_reg  <= 1'b0;
              end
            end
          endcase
          state_reg <= RESP;
        end

        RESP: begin
          resp_valid_reg <= 1'b1;
          resp_data_reg  <= result_data_reg;
          resp_err_reg   <= result_err_reg;
          ready_reg      <= 1'b1;
          state_reg      <= IDLE;
        end

        default: begin
          ready_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign reqReady  = ready_reg;
  assign respValid = resp_valid_reg;
  assign respData  = resp_data_reg;
  assign respError = resp_err_reg;
  assign inUse     = in_use_reg;
  assign highWater = high_water_reg;

endmodule

// File: tb/tb_array_allocator.sv
// Directed bench for array_allocator: requests push expected responses into a
// queue that an independent monitor pops and compares on each respValid pulse.
module tb_array_allocator;

  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] F = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] S = 2'd3;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [11:0] reqArray;
  logic [11:0] reqIndex;
  logic        respValid;
  logic [11:0] respData;
  logic        respError;
  logic [11:0] inUse;
  logic [11:0] highWater;

  array_allocator #(.MemoryElementWidth(12), .NArrays(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqOp     (reqOp),
    .reqArray  (reqArray),
    .reqIndex  (reqIndex),
    .respValid (respValid),
    .respData  (respData),
    .respError (respError),
    .inUse     (inUse),
    .highWater (highWater)
  );

  typedef struct {
    int tag;
    int data;
    int err;
    int use_cnt;
    int hw;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   tag_n  = 0;
  int   last_acc = -1;
  bit   hold_mode = 0;
  bit   prev_rv = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every response pulse against the head of the queue.
  always @(negedge clock) begin
    if (reset) begin
      if (respValid) begin
        if (prev_rv) begin
          checks++; errors++;
          $display("FAIL resp_back_to_back: respValid high two cycles in a row at cycle %0d", cycle);
        end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got data %0d err %0d, expected no response", respData, respError);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("resp #%0d: data=%0d err=%0d inUse=%0d highWater=%0d cycle=%0d",
                   e.tag, respData, respError, inUse, highWater, cycle);
          chk($sformatf("t%0d_data", e.tag), int'(respData), e.data);
          chk($sformatf("t%0d_err", e.tag), int'(respError), e.err);
          chk($sformatf("t%0d_inUse", e.tag), int'(inUse), e.use_cnt);
          chk($sformatf("t%0d_highWater", e.tag), int'(highWater), e.hw);
          chk($sformatf("t%0d_latency", e.tag), cycle - e.acc, 2);
        end
      end
      prev_rv = respValid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input int arr, input int idx,
                       input int ed, input int ee, input int eu, input int eh);
    int n;
    exp_t e;
    n = 0;
    reqOp    = op;
    reqArray = 12'(arr);
    reqIndex = 12'(idx);
    reqValid = 1'b1;
    while (!reqReady) begin
      @(posedge clock); #1;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: reqReady stayed 0, expected 1 within 50 cycles");
        reqValid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    if (hold_mode && last_acc >= 0) chk("accept_interval", cycle - last_acc, 3);
    last_acc  = cycle;
    e.tag     = tag_n;
    e.data    = ed;
    e.err     = ee;
    e.use_cnt = eu;
    e.hw      = eh;
    e.acc     = cycle;
    exp_q.push_back(e);
    $display("req #%0d: op=%0d array=%0d index=%0d accepted at cycle %0d", tag_n, op, arr, idx, cycle);
    tag_n++;
    if (!hold_mode) reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    reset    = 1'b0;
    reqValid = 1'b0;
    reqOp    = 2'd0;
    reqArray = '0;
    reqIndex = '0;
    #12;
    chk("rst_reqReady", int'(reqReady), 0);
    chk("rst_respValid", int'(respValid), 0);
    chk("rst_respData", int'(respData), 0);
    chk("rst_inUse", int'(inUse), 0);
    chk("rst_highWater", int'(highWater), 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    chk("first_reqReady", int'(reqReady), 1);

    // Sequencer pattern: alloc/free pairs keep reusing handle 0.
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(F, 0, 0, 0, 0, 0, 1);
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(F, 0, 0, 0, 0, 0, 1);
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(F, 0, 0, 0, 0, 0, 1);

    // Exhaustion, then LIFO reuse.
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(A, 0, 0, 1, 0, 2, 2);
    issue(A, 0, 0, 2, 0, 3, 3);
    issue(A, 0, 0, 3, 0, 4, 4);
    issue(A, 0, 0, 4, 0, 5, 5);
    issue(A, 0, 0, 5, 0, 6, 6);
    issue(A, 0, 0, 6, 0, 7, 7);
    issue(A, 0, 0, 7, 0, 8, 8);
    issue(A, 0, 0, 0, 1, 8, 8);
    issue(F, 3, 0, 3, 0, 7, 8);
    issue(F, 5, 0, 5, 0, 6, 8);
    issue(A, 0, 0, 5, 0, 7, 8);
    issue(A, 0, 0, 3, 0, 8, 8);
    drain();

    // Asynchronous reset while the FREE is in EXEC: no response, all outputs 0.
    reqOp = F; reqArray = 12'd7; reqIndex = '0; reqValid = 1'b1;
    @(posedge clock); #3;
    reset = 1'b0;
    reqValid = 1'b0;
    #1;
    chk("arst_reqReady", int'(reqReady), 0);
    chk("arst_respValid", int'(respValid), 0);
    chk("arst_respData", int'(respData), 0);
    chk("arst_respError", int'(respError), 0);
    chk("arst_inUse", int'(inUse), 0);
    chk("arst_highWater", int'(highWater), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // Resize / size, then error cases.
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(R, 0, 4, 0, 0, 1, 1);
    issue(R, 0, 2, 0, 0, 1, 1);
    issue(S, 0, 0, 5, 0, 1, 1);
    issue(F, 0, 0, 0, 0, 0, 1);
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(S, 0, 0, 0, 0, 1, 1);
    issue(F, 0, 0, 0, 0, 0, 1);
    issue(F, 0, 0, 0, 1, 0, 1);
    issue(S, 9, 0, 0, 1, 0, 1);
    issue(A, 0, 0, 0, 0, 1, 1);
    issue(R, 0, 3, 0, 0, 1, 1);
    issue(R, 0, 4095, 0, 1, 1, 1);
    issue(S, 0, 0, 4, 0, 1, 1);
    issue(R, 0, 1, 0, 0, 1, 1);
    issue(S, 0, 0, 4, 0, 1, 1);
    issue(F, 9, 0, 0, 1, 1, 1);
    issue(R, 1, 2, 0, 1, 1, 1);
    issue(S, 1, 0, 0, 1, 1, 1);
    drain();

    // reqValid held high throughout with alternating ALLOC/FREE.
    hold_mode = 1'b1;
    last_acc  = -1;
    issue(A, 0, 0, 1, 0, 2, 2);
    issue(F, 1, 0, 1, 0, 1, 2);
    issue(A, 0, 0, 1, 0, 2, 2);
    issue(F, 1, 0, 1, 0, 1, 2);
    issue(A, 0, 0, 1, 0, 2, 2);
    issue(F, 1, 0, 1, 0, 1, 2);
    hold_mode = 1'b0;
    reqValid  = 1'b0;
    drain();
    repeat (4) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
